// File: rtl/keypad_bcd_capture_pkg.sv
// Shared keypad definitions: debounce FSM states, the function-key base index
// and the one-hot to index decoder also used by the lock controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } key_state_e;

  localparam logic [3:0] KEY_FUNC_BASE = 4'd10;
  localparam int         MAX_KEYS      = 16;

  // Returns {exactly_one_bit_set, index_of_highest_set_bit}.
  function automatic logic [4:0] onehot_to_idx(input logic [MAX_KEYS-1:0] pattern);
    logic [3:0] idx;
    logic [4:0] ones;
    idx  = '0;
    ones = '0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (pattern[i]) begin
        idx  = 4'(i);
        ones = ones + 5'd1;
      end
    end
    return {(ones == 5'd1), idx};
  endfunction

endpackage

// File: rtl/keypad_bcd_capture_if.sv
// Keypad capture bus: raw key lines and clear in, decoded events and entry buffer out.
// With KEYPAD_BCD_ECHO_EN defined the bus also carries echo_onehot.
interface keypad_bcd_capture_if #(
  parameter int NUM_KEYS = 10,
  parameter int DIGITS   = 4
);
  localparam int CNT_W = $clog2(DIGITS + 1);

  logic [NUM_KEYS-1:0] key_in;
  logic                clr;
  logic                digit_valid;
  logic [3:0]          digit_bcd;
  logic                func_valid;
  logic [3:0]          func_code;
  logic                multi_err;
  logic [4*DIGITS-1:0] buf_bcd;
  logic [CNT_W-1:0]    count;
  logic                full;
`ifdef KEYPAD_BCD_ECHO_EN
  logic [NUM_KEYS-1:0] echo_onehot;
`endif

  // Keypad pins / controller side
  modport master (
    output key_in,
    output clr,
    input  digit_valid,
    input  digit_bcd,
    input  func_valid,
    input  func_code,
    input  multi_err,
    input  buf_bcd,
    input  count,
    input  full
`ifdef KEYPAD_BCD_ECHO_EN
    , input echo_onehot
`endif
  );

  // Capture block side
  modport slave (
    input  key_in,
    input  clr,
    output digit_valid,
    output digit_bcd,
    output func_valid,
    output func_code,
    output multi_err,
    output buf_bcd,
    output count,
    output full
`ifdef KEYPAD_BCD_ECHO_EN
    , output echo_onehot
`endif
  );

endinterface

// File: rtl/keypad_bcd_capture_key_debounce.sv
// Synchroniser, debounce counter and press/release FSM for the raw key lines.
// Emits a single-cycle press_evt together with the stable pattern on acceptance.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS   = 10,
  parameter int DEB_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic                press_evt,
  output logic [NUM_KEYS-1:0] press_pat
);

  localparam int               CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] ks_prev_q, ks_prev_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  key_state_e          state_q, state_d;

  logic [NUM_KEYS-1:0] ks;
  logic                ks_changed;
  logic                ks_zero;
  logic                stable;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_sync
    assign sync1_d[gi] = key_in[gi];
    assign sync2_d[gi] = sync1_q[gi];
  end

  assign ks         = sync2_q;
  assign ks_prev_d  = ks;
  assign ks_changed = (ks != ks_prev_q);
  assign ks_zero    = (ks == '0);
  // The current cycle must also match, so a change on the saturating cycle is not taken.
  assign stable     = (cnt_q == CNT_MAX) && !ks_changed;
  assign press_pat  = ks;

  always_comb begin
    cnt_d = cnt_q;
    if (ks_changed) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    press_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ks_zero) state_d = PRESS;
      end
      PRESS: begin
        if (ks_zero) begin
          state_d = IDLE;
        end else if (stable) begin
          state_d   = HELD;
          press_evt = 1'b1;
        end
      end
      HELD: begin
        if (ks_zero) state_d = RELEASE;
      end
      RELEASE: begin
        if (!ks_zero) begin
          state_d = HELD;
        end else if (stable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      ks_prev_q <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      ks_prev_q <= ks_prev_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: rtl/keypad_bcd_capture.sv
// Keypad front end: debounced key events decoded to BCD digits, function codes or
// multi-key errors, with a shift-in BCD entry buffer. Optional echo: KEYPAD_BCD_ECHO_EN.
module keypad_bcd_capture
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS   = 10,
  parameter int DIGITS     = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  keypad_bcd_capture_if.slave  bus
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int BUF_W = 4 * DIGITS;

  logic                press_evt;
  logic [NUM_KEYS-1:0] press_pat;
  logic [4:0]          decoded;
  logic                single;
  logic [3:0]          idx;
  logic                is_digit;
  logic                full_w;

  logic             digit_valid_q, digit_valid_d;
  logic [3:0]       digit_bcd_q, digit_bcd_d;
  logic             func_valid_q, func_valid_d;
  logic [3:0]       func_code_q, func_code_d;
  logic             multi_err_q, multi_err_d;
  logic [BUF_W-1:0] buf_bcd_q, buf_bcd_d;
  logic [CNT_W-1:0] count_q, count_d;

  key_debounce #(
    .NUM_KEYS   (NUM_KEYS),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .key_in    (bus.key_in),
    .press_evt (press_evt),
    .press_pat (press_pat)
  );

  assign decoded  = onehot_to_idx(MAX_KEYS'(press_pat));
  assign single   = decoded[4];
  assign idx      = decoded[3:0];
  assign is_digit = (idx < KEY_FUNC_BASE);
  assign full_w   = (count_q == CNT_W'(DIGITS));

  always_comb begin
    digit_valid_d = 1'b0;
    func_valid_d  = 1'b0;
    multi_err_d   = 1'b0;
    digit_bcd_d   = digit_bcd_q;
    func_code_d   = func_code_q;
    buf_bcd_d     = buf_bcd_q;
    count_d       = count_q;

    if (press_evt) begin
      if (!single) begin
        multi_err_d = 1'b1;
      end else if (is_digit) begin
        // digit_bcd tracks the key even when a full buffer or clr drops the digit
        digit_bcd_d = idx;
        if (!bus.clr && !full_w) begin
          digit_valid_d  = 1'b1;
          buf_bcd_d      = buf_bcd_q << 4;
          buf_bcd_d[3:0] = idx;
          count_d        = count_q + CNT_W'(1);
        end
      end else begin
        func_valid_d = 1'b1;
        func_code_d  = idx;
      end
    end

    if (bus.clr) begin
      buf_bcd_d = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_valid_q <= 1'b0;
      digit_bcd_q   <= '0;
      func_valid_q  <= 1'b0;
      func_code_q   <= '0;
      multi_err_q   <= 1'b0;
      buf_bcd_q     <= '0;
      count_q       <= '0;
    end else begin
      digit_valid_q <= digit_valid_d;
      digit_bcd_q   <= digit_bcd_d;
      func_valid_q  <= func_valid_d;
      func_code_q   <= func_code_d;
      multi_err_q   <= multi_err_d;
      buf_bcd_q     <= buf_bcd_d;
      count_q       <= count_d;
    end
  end

  assign bus.digit_valid = digit_valid_q;
  assign bus.digit_bcd   = digit_bcd_q;
  assign bus.func_valid  = func_valid_q;
  assign bus.func_code   = func_code_q;
  assign bus.multi_err   = multi_err_q;
  assign bus.buf_bcd     = buf_bcd_q;
  assign bus.count       = count_q;
  assign bus.full        = full_w;

`ifdef KEYPAD_BCD_ECHO_EN
  logic [NUM_KEYS-1:0] echo_q, echo_d;
  logic [NUM_KEYS-1:0] idx_onehot;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_echo
    assign idx_onehot[gi] = (idx == 4'(gi));
  end

  // Only keys that actually produced a digit or function pulse are echoed
  always_comb begin
    echo_d = echo_q;
    if (digit_valid_d || func_valid_d) begin
      echo_d = idx_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_q <= '0;
    end else begin
      echo_q <= echo_d;
    end
  end

  assign bus.echo_onehot = echo_q;
`endif

endmodule

// File: doc/keypad_bcd_capture.md
Name: keypad_bcd_capture

Overview:
Parametrised successor to the one-hot keypad → binary → one-hot decimal path used by the door-lock front end. Takes raw one-hot key lines, then synchronises, debounces and validates them, and encodes the accepted key to BCD. Digit keys (0-9) are shifted into a multi-digit BCD entry buffer. Keys above 9 (e.g. `*`, `#`) are reported as function codes. Sits between the keypad pins and the code-compare/lock controller.

Parameters:
- NUM_KEYS, 10, number of one-hot key lines; legal range 10..16; line i encodes to value i.
- DIGITS, 4, BCD entry-buffer depth in digits; legal range 1..8.
- DEB_CYCLES, 16, consecutive stable cycles required to accept a press or a release; minimum 2.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_in  in  NUM_KEYS  raw asynchronous one-hot key lines, active-high.
- clr  in  1  synchronous clear of the entry buffer; single-cycle pulse.
- digit_valid  out  1  one-cycle pulse: digit accepted into the buffer.
- digit_bcd  out  4  last accepted digit; held between pulses.
- func_valid  out  1  one-cycle pulse: function key (index ≥ 10) accepted.
- func_code  out  4  index of the last function key (0xA..0xF); held.
- multi_err  out  1  one-cycle pulse: stable pattern had more than one bit set.
- buf_bcd  out  4*DIGITS  entry buffer; nibble 0 holds the newest digit.
- count  out  $clog2(DIGITS+1)  number of digits held, 0..DIGITS.
- full  out  1  level: count == DIGITS.

Behaviour:
- Reset (`rst` = 1 at a clock edge): all outputs 0, synchroniser flops 0, debounce counter 0, FSM to IDLE. Reset mid-debounce or while a key is held discards all progress.
- Synchroniser: 2-flop chain on every `key_in` bit; `ks` is the synchronised pattern.
- Debounce counter:
  - Counter resets to 0 whenever `ks` differs from the previous cycle's `ks`; otherwise it increments, saturating at DEB_CYCLES-1.
  - A pattern is "stable" when the counter equals DEB_CYCLES-1.
- FSM states: IDLE, PRESS, HELD, RELEASE.
  - IDLE: `ks` ≠ 0 → PRESS.
  - PRESS: `ks` == 0 → IDLE, no event. Otherwise, when stable → HELD and one event is issued (see below).
  - HELD: `ks` == 0 → RELEASE. Other pattern changes, such as a second key added, are ignored and produce no event.
  - RELEASE: `ks` ≠ 0 → HELD. `ks` stable at 0 → IDLE.
- Event on the PRESS→HELD transition, registered so the outputs appear the cycle after stability:
  - Popcount > 1: `multi_err` pulses; no digit or function event.
  - Single bit at index i < 10:
    - `digit_bcd` = i.
    - If not full: `digit_valid` pulses, `buf_bcd` = {buf_bcd[4*DIGITS-5:0], i}, `count`++.
    - If full: buffer and `count` unchanged, `digit_valid` stays 0, `digit_bcd` still updates.
  - Single bit at index i ≥ 10: `func_valid` pulses, `func_code` = i; buffer unaffected.
- Latency: a new `key_in` pattern first sampled at edge t, held constant, gives the event pulse at edge t+2+DEB_CYCLES.
- `clr`: next edge sets `buf_bcd` = 0 and `count` = 0. The FSM is unaffected.
  - `clr` coincident with a digit event: `clr` wins and the digit is dropped (no `digit_valid`).
  - A coincident `func_valid` or `multi_err` is still issued.
- `full` is combinational from `count`. At most one of `digit_valid`, `func_valid`, `multi_err` is high in any cycle.

Optional Feature:
- Macro KEYPAD_BCD_ECHO_EN.
- When defined: adds output port `echo_onehot` [NUM_KEYS-1:0], a one-hot re-decode of the last accepted key.
  - Set together with `digit_valid` or `func_valid` (bit i = 1), cleared on reset.
  - Holds until the next accepted key; unchanged by `clr`.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package `keypad_pkg`:
  - FSM state enum (IDLE, PRESS, HELD, RELEASE).
  - Constant `KEY_FUNC_BASE` = 4'd10.
  - `function onehot_to_idx(pattern) → {valid_single, idx[3:0]}`, used both here and by the lock controller.
- Sub-module `key_debounce`: contains the synchroniser, debounce counter and FSM, and outputs a one-cycle `press_evt` with the stable pattern.
- Top module: event decode, BCD buffer, `clr` and the optional echo logic.

Test Plan (DEB_CYCLES=4, DIGITS=4, NUM_KEYS=12):
- Clean press: press key 7 for 10 cycles, then release → one `digit_valid` exactly 6 cycles after `key_in` sampled; `digit_bcd`=7, `buf_bcd`=0x0007, `count`=1; no second pulse on release.
- Bounce: key 3 toggling every 2 cycles for 12 cycles, then steady → exactly one event, after steady+6 cycles; `buf_bcd`=0x0003.
- Fill and overflow: press 1,2,3,4,5 → `buf_bcd`=0x1234, `full`=1, `count`=4; fifth press gives no `digit_valid` and `digit_bcd`=5.
- Multi-key and function key: keys 2 and 6 together → `multi_err` pulse, buffer unchanged. Key 11 → `func_valid`, `func_code`=0xB, buffer unchanged.
- `clr` collision: `clr` asserted on the same cycle as the digit-9 event with `count`=2 → `buf_bcd`=0, `count`=0, no `digit_valid`.
- Reset mid-operation: assert `rst` during HELD with `count`=3 → all outputs 0. Key still pressed after reset → a new event after 2+DEB_CYCLES cycles, with `buf_bcd`=that key.
